// File: rtl/mmio_fact_if.sv
// Core memory-stage port seen by the factorial accelerator. The core drives
// addr/wd/we; the accelerator returns read data, window hit and gated store enable.
interface mmio_fact_if;
   logic [31:0] addr;
   logic [31:0] wd;
   logic        we;
   logic [31:0] rd;
   logic        hit;
   logic        we_dm;

   modport master (output addr, output wd, output we,
                   input rd, input hit, input we_dm);
   modport slave  (input addr, input wd, input we,
                   output rd, output hit, output we_dm);
endinterface

// File: rtl/mmio_fact_accel.sv
// Memory-mapped iterative factorial accelerator: N/GO/STATUS/RESULT registers in a
// 16-byte window, store-enable gating toward data memory, sticky done/err status.
module mmio_fact_accel #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
   parameter int          MAX_N     = 12
) (
   input  logic        clk,
   input  logic        rst,
   mmio_fact_if.slave  bus,
   output logic        busy,
   output logic        done_irq,
   output logic        fsm_state
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   localparam logic [3:0] MAX_N_L = MAX_N[3:0];

   state_e      state_q, state_d;
   logic [3:0]  n_q, n_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] prod_q, prod_d;
   logic [31:0] result_q, result_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic [1:0]  off;
   logic        wr;
   logic        go_wr;

   assign off       = bus.addr[3:2];
   assign bus.hit   = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign bus.we_dm = bus.we & ~bus.hit;
   assign wr        = bus.we & bus.hit;
   assign go_wr     = wr && (off == 2'd1) && bus.wd[0];

   assign busy      = (state_q == BUSY);
   assign done_irq  = done_q;
   assign fsm_state = state_q;

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      result_d = result_q;
      done_d   = done_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (wr && off == 2'd0) begin
               n_d = bus.wd[3:0];
            end
            if (go_wr) begin
               if (n_q <= MAX_N_L) begin
                  state_d = BUSY;
                  cnt_d   = n_q;
                  prod_d  = 32'd1;
                  done_d  = 1'b0;
                  err_d   = 1'b0;
               end else begin
                  err_d    = 1'b1;
                  done_d   = 1'b1;
                  result_d = 32'd0;
               end
            end
         end
         BUSY: begin
            // cnt of 0 or 1 both finish with the accumulated product (0! = 1! = 1).
            if (cnt_q <= 4'd1) begin
               result_d = prod_q;
               done_d   = 1'b1;
               state_d  = IDLE;
            end else begin
               prod_d = prod_q * {28'd0, cnt_q};
               cnt_d  = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         n_q      <= 4'd0;
         cnt_q    <= 4'd0;
         prod_q   <= 32'd0;
         result_q <= 32'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         result_q <= result_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Read data is purely combinational so the core can capture it without a stall.
   always_comb begin
      bus.rd = 32'd0;
      if (bus.hit) begin
         case (off)
            2'd0: bus.rd = {28'd0, n_q};
            2'd1: bus.rd = {31'd0, busy};
            2'd2: bus.rd = {30'd0, err_q, done_q};
            2'd3: bus.rd = result_q;
            default: bus.rd = 32'd0;
         endcase
      end
   end

endmodule

// File: doc/mmio_fact_accel.md
Name: mmio_fact_accel

Overview:
- Memory-mapped factorial accelerator on the core's data-memory port, downstream of the core's memory-stage outputs (ALU address, store data, store enable).
- Decodes its own 16-byte window and gates the store enable toward data memory.
- Returns read data that the SoC multiplexes onto the core's load-data input.
- Computes n! iteratively with a control FSM and reports completion through a sticky status register.

Parameters:
- BASE_ADDR, 32'h0000_0800, base of the 16-byte register window; bits [3:0] are ignored.
- MAX_N, 12, largest n accepted; larger n sets the error flag (13! overflows 32 bits).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous active-low reset (0 = reset)
- addr  in  32  byte address from the core's memory stage
- wd  in  32  store data
- we  in  1  store enable from the core
- rd  out  32  read data for the window, combinational from addr and registered state; 0 when hit=0
- hit  out  1  addr[31:4] == BASE_ADDR[31:4], combinational
- we_dm  out  1  store enable to data memory = we & ~hit
- busy  out  1  FSM in BUSY
- done_irq  out  1  level copy of STATUS.done

Behaviour:
- Register map, word offset addr[3:2]:
  - 0x0 N: RW, bits [3:0], upper bits read 0.
  - 0x4 GO: write bit0=1 starts a computation; reads {31'b0, busy}.
  - 0x8 STATUS: RO, {30'b0, err, done}.
  - 0xC RESULT: RO, 32 bits.
- addr[1:0] is ignored; every access is a full word.
- A write occurs on a clock edge with we=1 and hit=1.
- Writes to STATUS or RESULT are ignored.
- Reset (rst=0, asynchronous): N=0, result=0, prod=0, cnt=0, done=0, err=0, state=IDLE. Outputs follow: rd=0, busy=0, done_irq=0. hit and we_dm stay combinational from their inputs.
- FSM states: IDLE, BUSY.
- IDLE, GO write with bit0=1, N<=MAX_N:
  - state<=BUSY, cnt<=N, prod<=1, done<=0, err<=0.
- IDLE, GO write with bit0=1, N>MAX_N:
  - err<=1, done<=1, result<=0, state stays IDLE.
- IDLE, GO write with bit0=0: no effect.
- BUSY, each edge with cnt<=1:
  - result<=prod, done<=1, state<=IDLE.
- BUSY, each edge with cnt>1:
  - prod<=prod*cnt (low 32 bits; no overflow for cnt<=12), cnt<=cnt-1.
- Latency: done rises max(N,1) edges after the GO-write edge.
  - N=0 and N=1 both give result 1 after 1 edge.
- While BUSY:
  - Writes to N and GO are ignored.
  - RESULT reads the previously completed value.
  - STATUS reads done=0.
- done and err are sticky until the next accepted GO.
- A write to N in the same edge as the FSM leaving BUSY is ignored (state is still BUSY at that edge).
- Reset mid-computation: the FSM aborts to IDLE, all registers clear, and no partial result is visible.
- Reads have no side effects.
- rd is valid in the same cycle as addr, so the core registers it into its writeback stage without a stall.

Test Plan:
1. Reset then idle: rst=0→1; read 0x800, 0x804, 0x808, 0x80C → all 0. Store to 0x100 → we_dm=1, hit=0; store to 0x808 → we_dm=0, hit=1.
2. N=5: write 0x800=5, write 0x804=1. busy=1 for 5 cycles; STATUS reads 0 during BUSY. Then STATUS=1, RESULT=120 (0x78), done_irq=1.
3. Boundaries:
   - N=0 → RESULT=1 after 1 edge.
   - N=1 → RESULT=1.
   - N=12 → RESULT=479001600 (0x1C8CFC00) after 12 edges.
4. Error: N=13, GO=1 → next cycle STATUS=3 (err=1, done=1), RESULT=0, busy never asserts. Then N=3, GO=1 → err clears; RESULT=6 after 3 edges.
5. Writes during BUSY: with N=6 running, write N=2 and GO=1 mid-run → ignored. RESULT=720, and N reads 6 afterward.
6. Reset mid-run: N=10, GO=1, assert rst=0 after 4 cycles → immediately busy=0 and all reads 0. After release, N=4, GO=1 → RESULT=24.
